// File: rtl/control_fsm.sv
//------------------------------------------------------------------------------
// control_fsm
//   Multicycle RISC-V control unit for a unified-memory datapath. One state
//   per datapath step; memory accesses wait on MemReady.
//
//   Parameters
//     ILLEGAL_HALT  1: unrecognised opcode parks the FSM in HALT.
//                   0: unrecognised opcode behaves as a NOP (DECODE -> FETCH).
//   Build option
//     CONTROL_FSM_JALR_EN  when defined, adds the JALR and JALRLINK states for
//                          Op 1100111. When undefined, that opcode is treated
//                          as unrecognised.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     Op, Funct3,     instruction fields used for sequencing and ALU decode
//     Funct7b5
//     Zero            ALU zero flag, used in BEQ
//     MemReady        memory completes the current access this cycle
//     PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//     ALUSrcB, ImmSrc, ALUControl   datapath controls
//     Halted          high while in HALT
//     state_dbg       current state encoding, for observation only
//
//   Memory handshake: the FSM holds its access request (address select and,
//   for stores, MemWrite) stable in a wait state for as long as MemReady is
//   low; the access is complete in the cycle MemReady is high, and only then
//   does the FSM move on. At most one access is requested per cycle.
//------------------------------------------------------------------------------
module control_fsm #(
   parameter int ILLEGAL_HALT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic [2:0] Funct3,
   input  logic       Funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Halted,
   output logic [3:0] state_dbg
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef CONTROL_FSM_JALR_EN
   localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
`ifdef CONTROL_FSM_JALR_EN
      S_JALR     = 4'd12,
      S_JALRLINK = 4'd13,
`endif
      S_HALT     = 4'd11
   } state_t;

   state_t     state_q, state_d;

   logic       pc_write, adr_src, mem_write, ir_write, reg_write, halted;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] alu_ctl, alu_dec;

   // ALU operation for EXECR/EXECI. Subtract only for R-type (Op[5]=1) with
   // Funct7b5 set; an I-type with that bit set (addi) still adds.
   always_comb begin
      alu_dec = ALU_ADD;
      case (Funct3)
         3'b000:  alu_dec = (Op[5] && Funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_dec = ALU_ADD;
      endcase
   end

   // Immediate format follows the opcode in every state.
   always_comb begin
      ImmSrc = 2'b00;
      case (Op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      halted     = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctl    = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            // PC + 4 goes straight from the ALU to the PC while the
            // instruction is latched; both wait for the read to complete.
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = MemReady;
            pc_write   = MemReady;
            if (MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Branch/jump target OldPC + imm computed speculatively.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
`ifdef CONTROL_FSM_JALR_EN
               OP_JALR:      state_d = S_JALR;
`endif
               default:      state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (MemReady) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_ctl   = alu_dec;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctl   = alu_dec;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            // Target was left in ALUOut by DECODE; take it only on equality.
            alu_src_a = 2'b10;
            alu_ctl   = ALU_SUB;
            pc_write  = Zero;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            // PC <- target from ALUOut while OldPC + 4 becomes the link value.
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
`ifdef CONTROL_FSM_JALR_EN
         S_JALR: begin
            // PC <- rs1 + imm directly from the ALU; bit 0 is kept as is.
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_d    = S_JALRLINK;
         end
         S_JALRLINK: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            state_d   = S_ALUWB;
         end
`endif
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Enables and Halted are forced low while reset is asserted, whatever the
   // current state.
   assign PCWrite    = pc_write  & ~rst;
   assign IRWrite    = ir_write  & ~rst;
   assign MemWrite   = mem_write & ~rst;
   assign RegWrite   = reg_write & ~rst;
   assign Halted     = halted    & ~rst;
   assign AdrSrc     = adr_src;
   assign ResultSrc  = result_src;
   assign ALUSrcA    = alu_src_a;
   assign ALUSrcB    = alu_src_b;
   assign ALUControl = alu_ctl;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

   // Expected-output word: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
   // ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halted}
   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       h;
   } outs_t;

   localparam int W = 34;   // {mask, expected}

   // Per-state expected outputs (ImmSrc filled in from Op when pushed).
   localparam outs_t E_FETCH1   = 17'b1_0_0_1_0_10_00_10_00_000_0;
   localparam outs_t E_FETCH0   = 17'b0_0_0_0_0_10_00_10_00_000_0;
   localparam outs_t E_DECODE   = 17'b0_0_0_0_0_00_01_01_00_000_0;
   localparam outs_t E_MEMADR   = 17'b0_0_0_0_0_00_10_01_00_000_0;
   localparam outs_t E_MEMREAD  = 17'b0_1_0_0_0_00_00_00_00_000_0;
   localparam outs_t E_MEMWB    = 17'b0_0_0_0_1_01_00_00_00_000_0;
   localparam outs_t E_MEMWRITE = 17'b0_1_1_0_0_00_00_00_00_000_0;
   localparam outs_t E_EXECR    = 17'b0_0_0_0_0_00_10_00_00_000_0;
   localparam outs_t E_EXECI    = 17'b0_0_0_0_0_00_10_01_00_000_0;
   localparam outs_t E_ALUWB    = 17'b0_0_0_0_1_00_00_00_00_000_0;
   localparam outs_t E_BEQ1     = 17'b1_0_0_0_0_00_10_00_00_001_0;
   localparam outs_t E_BEQ0     = 17'b0_0_0_0_0_00_10_00_00_001_0;
   localparam outs_t E_JAL      = 17'b1_0_0_0_0_00_01_10_00_000_0;
   localparam outs_t E_HALT     = 17'b0_0_0_0_0_00_00_00_00_000_1;
`ifdef CONTROL_FSM_JALR_EN
   localparam outs_t E_JALR     = 17'b1_0_0_0_0_10_10_01_00_000_0;
   localparam outs_t E_JALRLINK = 17'b0_0_0_0_0_00_01_10_00_000_0;
`endif
   localparam outs_t E_ZERO     = 17'b0;
   localparam outs_t M_FULL     = 17'h1ffff;
   localparam outs_t M_RST      = 17'b1_0_1_1_1_00_00_00_00_000_1;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] Op;
   logic [2:0] Funct3;
   logic       Funct7b5, Zero, MemReady;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Halted;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state_dbg;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_fsm dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
      .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Halted(Halted),
      .state_dbg(state_dbg)
   );

   outs_t act;
   assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halted};

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      case (o)
         7'b0100011: return 2'b01;
         7'b1100011: return 2'b10;
         7'b1101111: return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   function automatic outs_t with_alu(input outs_t b, input logic [2:0] a);
      outs_t r;
      r = b;
      r.alu = a;
      return r;
   endfunction

   // ---------------- driver ----------------
   task automatic set_op(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      Op = o; Funct3 = f3; Funct7b5 = f7;
   endtask

   // Drive one cycle's inputs and queue the outputs expected during it.
   task automatic step(input logic r, input logic mr, input logic z,
                       input outs_t e, input outs_t m);
      outs_t ee;
      rst = r; MemReady = mr; Zero = z;
      ee = e;
      ee.imm = imm_of(Op);
      exp_q.push_back({m, ee});
      @(posedge clk);
      #1;
   endtask

   task automatic go(input outs_t e);
      step(1'b0, 1'b1, 1'b0, e, M_FULL);
   endtask

   task automatic alu_seq(input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input outs_t ex);
      set_op(o, f3, f7);
      go(E_FETCH1); go(E_DECODE); go(ex); go(E_ALUWB);
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [W-1:0] ent;
   outs_t        em, ev;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ent = exp_q.pop_front();
         em  = ent[W-1:17];
         ev  = ent[16:0];
         checks++;
         if ((act & em) !== (ev & em)) begin
            errors++;
            $display("FAIL ctrl_out #%0d t=%0t: got %b, expected %b (mask %b)",
                     checks, $time, act, ev, em);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; MemReady = 1'b1; Zero = 1'b0;
      set_op(7'b0110011, 3'b000, 1'b1);
      @(posedge clk);
      #1;

      // Reset: enables and Halted low, whatever the state.
      step(1'b1, 1'b1, 1'b0, E_ZERO, M_RST);
      step(1'b1, 1'b0, 1'b0, E_ZERO, M_RST);

      // R-type and I-type ALU decode.
      alu_seq(7'b0110011, 3'b000, 1'b1, with_alu(E_EXECR, 3'b001));  // sub
      alu_seq(7'b0110011, 3'b000, 1'b0, with_alu(E_EXECR, 3'b000));  // add
      alu_seq(7'b0110011, 3'b010, 1'b0, with_alu(E_EXECR, 3'b101));  // slt
      alu_seq(7'b0110011, 3'b110, 1'b0, with_alu(E_EXECR, 3'b011));  // or
      alu_seq(7'b0110011, 3'b111, 1'b1, with_alu(E_EXECR, 3'b010));  // and
      alu_seq(7'b0110011, 3'b001, 1'b1, with_alu(E_EXECR, 3'b000));  // other
      alu_seq(7'b0010011, 3'b000, 1'b1, with_alu(E_EXECI, 3'b000));  // addi, b5 ignored
      alu_seq(7'b0010011, 3'b111, 1'b0, with_alu(E_EXECI, 3'b010));  // andi
      alu_seq(7'b0010011, 3'b010, 1'b0, with_alu(E_EXECI, 3'b101));  // slti

      // lw with three wait cycles in MEMREAD: 8 cycles in total.
      set_op(7'b0000011, 3'b010, 1'b0);
      go(E_FETCH1); go(E_DECODE); go(E_MEMADR);
      repeat (3) step(1'b0, 1'b0, 1'b0, E_MEMREAD, M_FULL);
      go(E_MEMREAD); go(E_MEMWB);

      // sw with a stalled fetch and one store wait cycle.
      set_op(7'b0100011, 3'b010, 1'b0);
      step(1'b0, 1'b0, 1'b0, E_FETCH0, M_FULL);
      step(1'b0, 1'b0, 1'b0, E_FETCH0, M_FULL);
      go(E_FETCH1); go(E_DECODE); go(E_MEMADR);
      step(1'b0, 1'b0, 1'b0, E_MEMWRITE, M_FULL);
      go(E_MEMWRITE);

      // beq taken and not taken.
      set_op(7'b1100011, 3'b000, 1'b0);
      go(E_FETCH1); go(E_DECODE);
      step(1'b0, 1'b1, 1'b1, E_BEQ1, M_FULL);
      go(E_FETCH1); go(E_DECODE);
      step(1'b0, 1'b1, 1'b0, E_BEQ0, M_FULL);

      // jal.
      set_op(7'b1101111, 3'b000, 1'b0);
      go(E_FETCH1); go(E_DECODE); go(E_JAL); go(E_ALUWB);

      // Reset in the middle of a stalled store.
      set_op(7'b0100011, 3'b010, 1'b0);
      go(E_FETCH1); go(E_DECODE); go(E_MEMADR);
      step(1'b0, 1'b0, 1'b0, E_MEMWRITE, M_FULL);
      step(1'b1, 1'b0, 1'b0, E_ZERO, M_RST);
      step(1'b0, 1'b0, 1'b0, E_FETCH0, M_FULL);
      go(E_FETCH1); go(E_DECODE); go(E_MEMADR); go(E_MEMWRITE);

      // jalr: real states when enabled, otherwise an illegal opcode.
      set_op(7'b1100111, 3'b000, 1'b0);
      go(E_FETCH1); go(E_DECODE);
`ifdef CONTROL_FSM_JALR_EN
      go(E_JALR); go(E_JALRLINK); go(E_ALUWB);
`else
      go(E_HALT); go(E_HALT);
      step(1'b1, 1'b1, 1'b0, E_ZERO, M_RST);
`endif

      // Illegal opcode: HALT holds for 20 cycles regardless of inputs,
      // and only reset leaves it.
      set_op(7'b0000000, 3'b000, 1'b0);
      go(E_FETCH1); go(E_DECODE);
      for (int i = 0; i < 20; i++)
         step(1'b0, i[0], i[1], E_HALT, M_FULL);
      step(1'b1, 1'b1, 1'b0, E_ZERO, M_RST);
      go(E_FETCH1);

      // Every queued expectation must have been consumed by now.
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
